// File: rtl/combo_lock_ctrl.sv
// Programmable CODE_LEN-digit combination lock with failure counting and timed alarm lockout.
// Define LOCK_REKEY_EN to let cmd_clear in OPEN return to INIT for reprogramming.
module combo_lock_ctrl #(
    parameter int CODE_LEN  = 8,
    parameter int DIGIT_W   = 4,
    parameter int MAX_TRIES = 3,
    parameter int ALARM_CYC = 500,
    parameter int BLINK_DIV = 50,
    localparam int POS_W    = $clog2(CODE_LEN + 1),
    localparam int FC_W     = $clog2(MAX_TRIES + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               digit_valid,
    input  logic [DIGIT_W-1:0] digit,
    input  logic               cmd_lock,
    input  logic               cmd_clear,
    output logic [1:0]         state,
    output logic [POS_W-1:0]   pos,
    output logic [FC_W-1:0]    fail_cnt,
    output logic               unlocked,
    output logic               alarm,
    output logic               alarm_blink
);

    localparam int TMR_W = (ALARM_CYC > 1) ? $clog2(ALARM_CYC) : 1;
    localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam int CODE_W = CODE_LEN * DIGIT_W;

    localparam logic [POS_W-1:0] POS_ZERO = {POS_W{1'b0}};
    localparam logic [POS_W-1:0] POS_ONE  = POS_W'(1);
    localparam logic [POS_W-1:0] POS_FULL = POS_W'(CODE_LEN);
    localparam logic [POS_W-1:0] POS_LAST = POS_W'(CODE_LEN - 1);
    localparam logic [FC_W-1:0]  FC_ZERO  = {FC_W{1'b0}};
    localparam logic [FC_W-1:0]  FC_ONE   = FC_W'(1);
    localparam logic [FC_W-1:0]  FC_MAX   = FC_W'(MAX_TRIES);
    localparam logic [FC_W-1:0]  FC_LAST  = FC_W'(MAX_TRIES - 1);
    localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
    localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ALARM_CYC - 1);
    localparam logic [BLK_W-1:0] BLK_ZERO = {BLK_W{1'b0}};
    localparam logic [BLK_W-1:0] BLK_ONE  = BLK_W'(1);
    localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_LOCKED = 2'd1,
        ST_OPEN   = 2'd2,
        ST_ALARM  = 2'd3
    } state_t;

    state_t              state_r, state_nxt_s;
    logic [POS_W-1:0]    pos_r, pos_nxt_s;
    logic [CODE_W-1:0]   code_r, code_nxt_s;
    logic                err_r, err_nxt_s;
    logic [FC_W-1:0]     fail_r, fail_nxt_s;
    logic [TMR_W-1:0]    tmr_r, tmr_nxt_s;
    logic [BLK_W-1:0]    blk_cnt_r, blk_cnt_nxt_s;
    logic                blink_r, blink_nxt_s;
    logic                unlocked_r, unlocked_nxt_s;
    logic                alarm_r, alarm_nxt_s;
    logic [DIGIT_W-1:0]  cur_digit_s;

    function automatic logic [DIGIT_W-1:0] code_digit(input logic [CODE_W-1:0] code,
                                                      input logic [POS_W-1:0] idx);
        logic [DIGIT_W-1:0] d;
        d = {DIGIT_W{1'b0}};
        for (int i = 0; i < CODE_LEN; i++) begin
            d = (idx == POS_W'(i)) ? code[i*DIGIT_W +: DIGIT_W] : d;
        end
        return d;
    endfunction

    function automatic logic [CODE_W-1:0] code_write(input logic [CODE_W-1:0] code,
                                                     input logic [POS_W-1:0] idx,
                                                     input logic [DIGIT_W-1:0] d);
        logic [CODE_W-1:0] c;
        c = code;
        for (int i = 0; i < CODE_LEN; i++) begin
            c[i*DIGIT_W +: DIGIT_W] = (idx == POS_W'(i)) ? d : code[i*DIGIT_W +: DIGIT_W];
        end
        return c;
    endfunction

    assign cur_digit_s = code_digit(code_r, pos_r);

    // State and datapath registers, including the registered output flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_INIT;
            pos_r      <= POS_ZERO;
            code_r     <= {CODE_W{1'b0}};
            err_r      <= 1'b0;
            fail_r     <= FC_ZERO;
            tmr_r      <= TMR_ZERO;
            blk_cnt_r  <= BLK_ZERO;
            blink_r    <= 1'b0;
            unlocked_r <= 1'b0;
            alarm_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            pos_r      <= pos_nxt_s;
            code_r     <= code_nxt_s;
            err_r      <= err_nxt_s;
            fail_r     <= fail_nxt_s;
            tmr_r      <= tmr_nxt_s;
            blk_cnt_r  <= blk_cnt_nxt_s;
            blink_r    <= blink_nxt_s;
            unlocked_r <= unlocked_nxt_s;
            alarm_r    <= alarm_nxt_s;
        end
    end

    // Next-state and datapath update; strobe priority is lock, then clear, then digit.
    always_comb begin
        state_nxt_s   = state_r;
        pos_nxt_s     = pos_r;
        code_nxt_s    = code_r;
        err_nxt_s     = err_r;
        fail_nxt_s    = fail_r;
        tmr_nxt_s     = tmr_r;
        blk_cnt_nxt_s = blk_cnt_r;
        blink_nxt_s   = blink_r;
        case (state_r)
            ST_INIT: begin
                if (cmd_lock) begin
                    if (pos_r == POS_FULL) begin
                        state_nxt_s = ST_LOCKED;
                        pos_nxt_s   = POS_ZERO;
                    end else begin
                        pos_nxt_s = pos_r;
                    end
                end else if (cmd_clear) begin
                    pos_nxt_s = POS_ZERO;
                end else if (digit_valid && (pos_r != POS_FULL)) begin
                    code_nxt_s = code_write(code_r, pos_r, digit);
                    pos_nxt_s  = pos_r + POS_ONE;
                end else begin
                    pos_nxt_s = pos_r;
                end
            end
            ST_LOCKED: begin
                if (cmd_lock) begin
                    state_nxt_s = ST_LOCKED;
                end else if (cmd_clear) begin
                    pos_nxt_s = POS_ZERO;
                    err_nxt_s = 1'b0;
                end else if (digit_valid) begin
                    // The verdict is withheld until the final digit of the entry.
                    if (pos_r == POS_LAST) begin
                        pos_nxt_s = POS_ZERO;
                        err_nxt_s = 1'b0;
                        if (!err_r && (digit == cur_digit_s)) begin
                            state_nxt_s = ST_OPEN;
                            fail_nxt_s  = FC_ZERO;
                        end else if (fail_r == FC_LAST) begin
                            state_nxt_s   = ST_ALARM;
                            fail_nxt_s    = FC_MAX;
                            tmr_nxt_s     = TMR_ZERO;
                            blk_cnt_nxt_s = BLK_ZERO;
                            blink_nxt_s   = 1'b1;
                        end else if (fail_r != FC_MAX) begin
                            fail_nxt_s = fail_r + FC_ONE;
                        end else begin
                            fail_nxt_s = fail_r;
                        end
                    end else begin
                        pos_nxt_s = pos_r + POS_ONE;
                        err_nxt_s = err_r | (digit != cur_digit_s);
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_OPEN: begin
                if (cmd_lock) begin
                    state_nxt_s = ST_LOCKED;
                    pos_nxt_s   = POS_ZERO;
                end else if (cmd_clear) begin
`ifdef LOCK_REKEY_EN
                    state_nxt_s = ST_INIT;
                    pos_nxt_s   = POS_ZERO;
`else
                    state_nxt_s = state_r;
`endif
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_ALARM: begin
                if (tmr_r == TMR_LAST) begin
                    state_nxt_s   = ST_LOCKED;
                    fail_nxt_s    = FC_ZERO;
                    tmr_nxt_s     = TMR_ZERO;
                    blk_cnt_nxt_s = BLK_ZERO;
                    blink_nxt_s   = 1'b0;
                end else begin
                    tmr_nxt_s = tmr_r + TMR_ONE;
                    if (blk_cnt_r == BLK_LAST) begin
                        blk_cnt_nxt_s = BLK_ZERO;
                        blink_nxt_s   = ~blink_r;
                    end else begin
                        blk_cnt_nxt_s = blk_cnt_r + BLK_ONE;
                    end
                end
            end
            default: begin
                state_nxt_s = ST_INIT;
            end
        endcase
    end

    // Output flags decoded from the next state so they register alongside it.
    always_comb begin
        unlocked_nxt_s = (state_nxt_s == ST_OPEN);
        alarm_nxt_s    = (state_nxt_s == ST_ALARM);
    end

    assign state       = state_r;
    assign pos         = pos_r;
    assign fail_cnt    = fail_r;
    assign unlocked    = unlocked_r;
    assign alarm       = alarm_r;
    assign alarm_blink = blink_r;

endmodule

// File: tb/tb_combo_lock_ctrl.sv
// Directed bench for combo_lock_ctrl with a behavioural reference model and per-cycle compare.
module tb_combo_lock_ctrl;

    localparam int CODE_LEN  = 4;
    localparam int DIGIT_W   = 4;
    localparam int MAX_TRIES = 3;
    localparam int ALARM_CYC = 20;
    localparam int BLINK_DIV = 5;
`ifdef LOCK_REKEY_EN
    localparam int REKEY = 1;
`else
    localparam int REKEY = 0;
`endif

    logic               clk;
    logic               rst_n;
    logic               digit_valid;
    logic [DIGIT_W-1:0] digit;
    logic               cmd_lock;
    logic               cmd_clear;
    logic [1:0]         state;
    logic [2:0]         pos;
    logic [1:0]         fail_cnt;
    logic               unlocked;
    logic               alarm;
    logic               alarm_blink;

    combo_lock_ctrl #(
        .CODE_LEN(CODE_LEN), .DIGIT_W(DIGIT_W), .MAX_TRIES(MAX_TRIES),
        .ALARM_CYC(ALARM_CYC), .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .digit_valid(digit_valid), .digit(digit),
        .cmd_lock(cmd_lock), .cmd_clear(cmd_clear), .state(state), .pos(pos),
        .fail_cnt(fail_cnt), .unlocked(unlocked), .alarm(alarm), .alarm_blink(alarm_blink)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // Reference model: observable lock state in plain integers.
    int m_state, m_pos, m_fail, m_acnt;
    int m_code[CODE_LEN];
    int m_entry[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_pos = 0; m_fail = 0; m_acnt = 0;
        for (int i = 0; i < CODE_LEN; i++) m_code[i] = 0;
        m_entry.delete();
    endtask

    task automatic model_update(input bit dv, input int d, input bit lk, input bit cl);
        bit ok;
        case (m_state)
            0: begin
                if (lk) begin
                    if (m_pos == CODE_LEN) begin m_state = 1; m_pos = 0; end
                end else if (cl) begin
                    m_pos = 0;
                end else if (dv && m_pos < CODE_LEN) begin
                    m_code[m_pos] = d; m_pos++;
                end
            end
            1: begin
                if (lk) begin
                end else if (cl) begin
                    m_entry.delete();
                end else if (dv) begin
                    m_entry.push_back(d);
                    if (m_entry.size() == CODE_LEN) begin
                        ok = 1'b1;
                        for (int i = 0; i < CODE_LEN; i++) if (m_entry[i] != m_code[i]) ok = 1'b0;
                        m_entry.delete();
                        if (ok) begin m_state = 2; m_fail = 0; end
                        else if (m_fail + 1 >= MAX_TRIES) begin m_state = 3; m_fail = MAX_TRIES; m_acnt = 0; end
                        else m_fail++;
                    end
                end
                m_pos = m_entry.size();
            end
            2: begin
                if (lk) begin m_state = 1; m_pos = 0; end
                else if (cl && REKEY != 0) begin m_state = 0; m_pos = 0; end
            end
            default: begin
                m_acnt++;
                if (m_acnt == ALARM_CYC) begin m_state = 1; m_fail = 0; m_pos = 0; end
            end
        endcase
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("state", state, m_state);
            chk("pos", pos, m_pos);
            chk("fail_cnt", fail_cnt, m_fail);
            chk("unlocked", unlocked, int'(m_state == 2));
            chk("alarm", alarm, int'(m_state == 3));
            chk("alarm_blink", alarm_blink, int'(m_state == 3 && ((m_acnt / BLINK_DIV) % 2) == 0));
        end
    end

    task automatic step(input bit dv, input int d, input bit lk, input bit cl);
        digit_valid = dv; digit = 4'(d); cmd_lock = lk; cmd_clear = cl;
        @(posedge clk);
        model_update(dv, d, lk, cl);
        #1;
        digit_valid = 1'b0; cmd_lock = 1'b0; cmd_clear = 1'b0;
        @(negedge clk);
    endtask

    task automatic enter4(input int a, input int b, input int c, input int e);
        step(1, a, 0, 0); step(1, b, 0, 0); step(1, c, 0, 0); step(1, e, 0, 0);
    endtask

    task automatic do_reset();
        #1;
        chk_en = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_state", state, 0);
        chk("rst_pos", pos, 0);
        chk("rst_fail", fail_cnt, 0);
        chk("rst_flags", {unlocked, alarm, alarm_blink}, 0);
        model_reset();
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; digit_valid = 1'b0; digit = 4'h0; cmd_lock = 1'b0; cmd_clear = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Programming, short lock, and no wrap past CODE_LEN.
        step(1, 3, 0, 0); step(1, 10, 0, 0); step(1, 0, 0, 0);
        step(0, 0, 1, 0);
        chk("short_lock_state", state, 0);
        chk("short_lock_pos", pos, 3);
        step(1, 15, 0, 0);
        chk("prog_full_pos", pos, 4);
        step(1, 7, 0, 0);
        chk("prog_no_wrap", pos, 4);
        step(0, 0, 1, 0);
        chk("prog_locked", state, 1);
        chk("prog_locked_pos", pos, 0);

        // Correct entry opens, lock relocks.
        enter4(3, 10, 0, 15);
        chk("open_state", state, 2);
        chk("open_unlocked", unlocked, 1);
        chk("open_fail", fail_cnt, 0);
        step(0, 0, 1, 0);
        chk("relock_state", state, 1);

        // Wrong digit is silent until the entry is complete.
        step(1, 3, 0, 0); step(1, 11, 0, 0); step(1, 0, 0, 0);
        chk("early_state", state, 1);
        chk("early_alarm", alarm, 0);
        step(1, 15, 0, 0);
        chk("wrong_fail", fail_cnt, 1);
        chk("wrong_pos", pos, 0);

        // Third failure triggers ALARM; strobes ignored while it runs.
        enter4(0, 0, 0, 0);
        chk("fail2", fail_cnt, 2);
        enter4(3, 10, 0, 14);
        chk("alarm_state", state, 3);
        chk("alarm_flag", alarm, 1);
        chk("alarm_fail", fail_cnt, 3);
        for (int i = 0; i < ALARM_CYC - 1; i++) begin
            step(1, i % 16, (i % 2) == 1, (i % 3) == 0);
            if (i == 0) chk("blink_start", alarm_blink, 1);
            if (i == 4) chk("blink_low", alarm_blink, 0);
            if (i == 9) chk("blink_high", alarm_blink, 1);
        end
        chk("alarm_hold", state, 3);
        step(0, 0, 0, 0);
        chk("alarm_exit_state", state, 1);
        chk("alarm_exit_fail", fail_cnt, 0);

        // Clear keeps fail_cnt; clear beats digit; lock beats digit.
        enter4(1, 1, 1, 1);
        step(1, 3, 0, 0); step(1, 10, 0, 0);
        step(0, 0, 0, 1);
        chk("clear_pos", pos, 0);
        chk("clear_keeps_fail", fail_cnt, 1);
        step(1, 3, 0, 1);
        chk("clear_beats_digit", pos, 0);
        enter4(3, 10, 0, 15);
        chk("reopen_state", state, 2);
        step(1, 3, 1, 0);
        chk("lock_wins_state", state, 1);
        chk("lock_wins_pos", pos, 0);
        step(1, 3, 0, 0);
        step(0, 0, 0, 1);

        // cmd_clear in OPEN depends on the rekey build option.
        enter4(3, 10, 0, 15);
        step(0, 0, 0, 1);
        chk("open_clear", state, (REKEY != 0) ? 0 : 2);
        if (REKEY != 0) begin
            enter4(1, 2, 3, 4);
            step(0, 0, 1, 0);
            enter4(1, 2, 3, 4);
            chk("rekey_open", state, 2);
        end
        step(0, 0, 1, 0);

        // Reset in the middle of ALARM.
        enter4(5, 5, 5, 5); enter4(5, 5, 5, 5); enter4(5, 5, 5, 5);
        chk("alarm2_state", state, 3);
        step(0, 0, 0, 0); step(0, 0, 0, 0);
        do_reset();
        step(0, 0, 1, 0);
        chk("post_rst_lock_ignored", state, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
